// File: rtl/instruction_queue_feeder_pkg.sv
// Shared control-unit types: instruction type codes, payload widths,
// the feeder state encoding and a bundled loop-instruction struct.
package instruction_queue_feeder_pkg;

  localparam logic [1:0] INSTR_TYPE_ARITHMETIC = 2'd0;
  localparam logic [1:0] INSTR_TYPE_RAM        = 2'd1;
  localparam logic [1:0] INSTR_TYPE_LD_ST      = 2'd2;
  localparam logic [1:0] INSTR_TYPE_RESERVED   = 2'd3;

  localparam int ARITH_INSTR_W = 14;
  localparam int RAM_INSTR_W   = 9;
  localparam int LD_ST_INSTR_W = 10;

  localparam int DEF_ADDR_WIDTH  = 18;
  localparam int DEF_COUNT_WIDTH = 16;

  typedef enum logic [0:0] {
    FEEDER_IDLE  = 1'b0,
    FEEDER_ISSUE = 1'b1
  } feeder_state_e;

  // One decoded loop instruction as handed over by the decoder.
  typedef struct packed {
    logic [1:0]                 instr_type;
    logic [0:ARITH_INSTR_W-1]   arith_instr;
    logic [0:RAM_INSTR_W-1]     ram_instr;
    logic [0:LD_ST_INSTR_W-1]   ld_st_instr;
    logic [DEF_ADDR_WIDTH-1:0]  cache_addr;
    logic [DEF_ADDR_WIDTH-1:0]  main_mem_addr;
    logic [DEF_ADDR_WIDTH-1:0]  d_cache_addr;
    logic [DEF_ADDR_WIDTH-1:0]  d_main_mem_addr;
    logic [DEF_COUNT_WIDTH-1:0] iter_count;
  } loop_instr_t;

endpackage

// File: rtl/instruction_queue_feeder_if.sv
// Decoder-side handshake plus queue-write bus of the feeder.
// master: the feeder itself; slave: decoder + instruction_queue side.
interface instruction_queue_feeder_if
  import instruction_queue_feeder_pkg::*;
#(
  parameter int LOG_SUPERSCALAR_WIDTH = 3,
  parameter int ADDR_WIDTH            = 18,
  parameter int COUNT_WIDTH           = 16
);

  logic                           in_valid;
  logic                           in_ready;
  logic [1:0]                     in_instr_type;
  logic [0:ARITH_INSTR_W-1]       in_arith_instr;
  logic [0:RAM_INSTR_W-1]         in_ram_instr;
  logic [0:LD_ST_INSTR_W-1]       in_ld_st_instr;
  logic [ADDR_WIDTH-1:0]          in_cache_addr;
  logic [ADDR_WIDTH-1:0]          in_main_mem_addr;
  logic [ADDR_WIDTH-1:0]          in_d_cache_addr;
  logic [ADDR_WIDTH-1:0]          in_d_main_mem_addr;
  logic [COUNT_WIDTH-1:0]         in_iter_count;

  logic                           full;
  logic                           we;
  logic [1:0]                     instr_type;
  logic [LOG_SUPERSCALAR_WIDTH:0] copy_count;
  logic [ADDR_WIDTH-1:0]          cache_addr;
  logic [ADDR_WIDTH-1:0]          main_mem_addr;
  logic [ADDR_WIDTH-1:0]          d_cache_addr;
  logic [ADDR_WIDTH-1:0]          d_main_mem_addr;
  logic [0:ARITH_INSTR_W-1]       arith_instr;
  logic [0:RAM_INSTR_W-1]         ram_instr;
  logic [0:LD_ST_INSTR_W-1]       ld_st_instr;

  modport master (
    input  in_valid, in_instr_type, in_arith_instr, in_ram_instr, in_ld_st_instr,
           in_cache_addr, in_main_mem_addr, in_d_cache_addr, in_d_main_mem_addr,
           in_iter_count, full,
    output in_ready, we, instr_type, copy_count, cache_addr, main_mem_addr,
           d_cache_addr, d_main_mem_addr, arith_instr, ram_instr, ld_st_instr
  );

  modport slave (
    output in_valid, in_instr_type, in_arith_instr, in_ram_instr, in_ld_st_instr,
           in_cache_addr, in_main_mem_addr, in_d_cache_addr, in_d_main_mem_addr,
           in_iter_count, full,
    input  in_ready, we, instr_type, copy_count, cache_addr, main_mem_addr,
           d_cache_addr, d_main_mem_addr, arith_instr, ram_instr, ld_st_instr
  );

endinterface

// File: rtl/instruction_queue_feeder_addr_advance.sv
// Combinational base + stride * chunk, wrapping modulo 2^ADDR_WIDTH.
module addr_advance #(
  parameter int ADDR_WIDTH            = 18,
  parameter int LOG_SUPERSCALAR_WIDTH = 3
) (
  input  logic [ADDR_WIDTH-1:0]          base,
  input  logic [ADDR_WIDTH-1:0]          stride,
  input  logic [LOG_SUPERSCALAR_WIDTH:0] chunk,
  output logic [ADDR_WIDTH-1:0]          next_addr
);

  logic [ADDR_WIDTH-1:0] product;

  // Shift-add multiply; chunk is small so this is a handful of adders.
  always_comb begin
    product = '0;
    for (int i = 0; i <= LOG_SUPERSCALAR_WIDTH; i++) begin
      if (chunk[i]) product = product + (stride << i);
    end
    next_addr = base + product;
  end

endmodule

// File: rtl/instruction_queue_feeder.sv
// Splits a loop instruction into superscalar chunks and issues one
// instruction_queue write per chunk, honouring the queue's full flag.
module instruction_queue_feeder
  import instruction_queue_feeder_pkg::*;
#(
  parameter int LOG_SUPERSCALAR_WIDTH = 3,
  parameter int ADDR_WIDTH            = 18,
  parameter int COUNT_WIDTH           = 16
) (
  input logic                  clk,
  input logic                  reset,
  instruction_queue_feeder_if.master bus
);

  localparam int                     MAX_CHUNK     = 2 ** LOG_SUPERSCALAR_WIDTH;
  localparam logic [COUNT_WIDTH-1:0] MAX_CHUNK_CNT = COUNT_WIDTH'(MAX_CHUNK);

  feeder_state_e state_q, state_d;

  logic [COUNT_WIDTH-1:0]         remaining_q;
  logic [1:0]                     type_q;
  logic [0:ARITH_INSTR_W-1]       arith_q;
  logic [0:RAM_INSTR_W-1]         ram_q;
  logic [0:LD_ST_INSTR_W-1]       ld_st_q;
  logic [ADDR_WIDTH-1:0]          cache_q, main_q, d_cache_q, d_main_q;
  logic [ADDR_WIDTH-1:0]          cache_next, main_next;
  logic [LOG_SUPERSCALAR_WIDTH:0] chunk;
  logic                           in_ready_int, xfer, accept, write;

  assign in_ready_int = (state_q == FEEDER_IDLE) && !reset;
  assign xfer         = bus.in_valid && in_ready_int;
  // Zero-count instructions are consumed but never latched.
  assign accept       = xfer && (bus.in_iter_count != '0);
  assign write        = (state_q == FEEDER_ISSUE) && !bus.full && !reset;

  // Current chunk size: min(remaining, max chunk).
  always_comb begin
    if (remaining_q > MAX_CHUNK_CNT) chunk = (LOG_SUPERSCALAR_WIDTH+1)'(MAX_CHUNK);
    else                             chunk = remaining_q[LOG_SUPERSCALAR_WIDTH:0];
  end

  addr_advance #(.ADDR_WIDTH(ADDR_WIDTH), .LOG_SUPERSCALAR_WIDTH(LOG_SUPERSCALAR_WIDTH))
    u_cache_adv (.base(cache_q), .stride(d_cache_q), .chunk(chunk), .next_addr(cache_next));

  addr_advance #(.ADDR_WIDTH(ADDR_WIDTH), .LOG_SUPERSCALAR_WIDTH(LOG_SUPERSCALAR_WIDTH))
    u_main_adv (.base(main_q), .stride(d_main_q), .chunk(chunk), .next_addr(main_next));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= FEEDER_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: leave ISSUE once the final chunk has been written.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FEEDER_IDLE:  if (accept) state_d = FEEDER_ISSUE;
      FEEDER_ISSUE: if (write && remaining_q == COUNT_WIDTH'(chunk)) state_d = FEEDER_IDLE;
      default:      state_d = FEEDER_IDLE;
    endcase
  end

  // Held instruction fields and per-chunk address/count advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      remaining_q <= '0;
      type_q      <= '0;
      arith_q     <= '0;
      ram_q       <= '0;
      ld_st_q     <= '0;
      cache_q     <= '0;
      main_q      <= '0;
      d_cache_q   <= '0;
      d_main_q    <= '0;
    end else if (accept) begin
      remaining_q <= bus.in_iter_count;
      type_q      <= bus.in_instr_type;
      arith_q     <= bus.in_arith_instr;
      ram_q       <= bus.in_ram_instr;
      ld_st_q     <= bus.in_ld_st_instr;
      cache_q     <= bus.in_cache_addr;
      main_q      <= bus.in_main_mem_addr;
      d_cache_q   <= bus.in_d_cache_addr;
      d_main_q    <= bus.in_d_main_mem_addr;
    end else if (write) begin
      remaining_q <= remaining_q - COUNT_WIDTH'(chunk);
      cache_q     <= cache_next;
      main_q      <= main_next;
    end
  end

  // Output drive; copy_count is only meaningful while issuing.
  always_comb begin
    bus.in_ready        = in_ready_int;
    bus.we              = write;
    bus.copy_count      = (state_q == FEEDER_ISSUE) ? chunk - 1'b1 : '0;
    bus.instr_type      = type_q;
    bus.arith_instr     = arith_q;
    bus.ram_instr       = ram_q;
    bus.ld_st_instr     = ld_st_q;
    bus.cache_addr      = cache_q;
    bus.main_mem_addr   = main_q;
    bus.d_cache_addr    = d_cache_q;
    bus.d_main_mem_addr = d_main_q;
  end

endmodule

// File: tb/tb_instruction_queue_feeder.sv
// Self-checking bench: directed cases plus random loop instructions
// checked against a per-copy arithmetic reference model.
module tb_instruction_queue_feeder;
  import instruction_queue_feeder_pkg::*;

  localparam int LSW = 3;
  localparam int AW  = 18;
  localparam int CW  = 16;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  instruction_queue_feeder_if #(.LOG_SUPERSCALAR_WIDTH(LSW), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) bus ();

  instruction_queue_feeder #(.LOG_SUPERSCALAR_WIDTH(LSW), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic scramble_inputs();
    bus.in_instr_type      = 2'($urandom);
    bus.in_arith_instr     = 14'($urandom);
    bus.in_ram_instr       = 9'($urandom);
    bus.in_ld_st_instr     = 10'($urandom);
    bus.in_cache_addr      = 18'($urandom);
    bus.in_main_mem_addr   = 18'($urandom);
    bus.in_d_cache_addr    = 18'($urandom);
    bus.in_d_main_mem_addr = 18'($urandom);
    bus.in_iter_count      = 16'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_type"},  64'(bus.instr_type), 64'd0);
    check_val({tag, "_cc"},    64'(bus.copy_count), 64'd0);
    check_val({tag, "_addrs"}, 64'({bus.cache_addr, bus.main_mem_addr}), 64'd0);
    check_val({tag, "_strd"},  64'({bus.d_cache_addr, bus.d_main_mem_addr}), 64'd0);
    check_val({tag, "_pay"},   64'({bus.arith_instr, bus.ram_instr, bus.ld_st_instr}), 64'd0);
  endtask

  function automatic loop_instr_t mk(input logic [1:0] t, input logic [13:0] a, input logic [8:0] r,
                                     input logic [9:0] l, input logic [17:0] ca, input logic [17:0] ma,
                                     input logic [17:0] dca, input logic [17:0] dma, input logic [15:0] n);
    loop_instr_t x;
    x.instr_type = t; x.arith_instr = a; x.ram_instr = r; x.ld_st_instr = l;
    x.cache_addr = ca; x.main_mem_addr = ma; x.d_cache_addr = dca; x.d_main_mem_addr = dma;
    x.iter_count = n;
    return x;
  endfunction

  // Called at a negedge with the feeder idle; returns at a negedge with it idle again.
  task automatic run_instr(input loop_instr_t ins, input int full_pct, input int stall_at);
    int n, done, cyc, c, budget;
    logic f;
    logic [17:0] exp_c, exp_m;
    n = int'(ins.iter_count);
    bus.in_valid           = 1'b1;
    bus.full               = 1'b0;
    bus.in_instr_type      = ins.instr_type;
    bus.in_arith_instr     = ins.arith_instr;
    bus.in_ram_instr       = ins.ram_instr;
    bus.in_ld_st_instr     = ins.ld_st_instr;
    bus.in_cache_addr      = ins.cache_addr;
    bus.in_main_mem_addr   = ins.main_mem_addr;
    bus.in_d_cache_addr    = ins.d_cache_addr;
    bus.in_d_main_mem_addr = ins.d_main_mem_addr;
    bus.in_iter_count      = ins.iter_count;
    #1;
    check_val("accept_ready", 64'(bus.in_ready), 64'd1);
    check_val("accept_no_we", 64'(bus.we), 64'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    scramble_inputs();
    if (n == 0) begin
      repeat (3) begin
        #1;
        check_val("zero_no_we", 64'(bus.we), 64'd0);
        check_val("zero_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
      end
      return;
    end
    done   = 0;
    cyc    = 0;
    budget = 6 * n + 50;
    while (done < n && cyc < budget) begin
      c = (n - done > 8) ? 8 : n - done;
      f = (stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 3) ||
          (int'($urandom_range(99)) < full_pct);
      bus.full = f;
      #1;
      exp_c = 18'(longint'(ins.cache_addr) + longint'(ins.d_cache_addr) * done);
      exp_m = 18'(longint'(ins.main_mem_addr) + longint'(ins.d_main_mem_addr) * done);
      check_val("we",         64'(bus.we), 64'(!f));
      check_val("busy_ready", 64'(bus.in_ready), 64'd0);
      check_val("copy_count", 64'(bus.copy_count), 64'(c - 1));
      check_val("cache_addr", 64'(bus.cache_addr), 64'(exp_c));
      check_val("main_addr",  64'(bus.main_mem_addr), 64'(exp_m));
      check_val("strides",    64'({bus.d_cache_addr, bus.d_main_mem_addr}),
                              64'({ins.d_cache_addr, ins.d_main_mem_addr}));
      check_val("instr_type", 64'(bus.instr_type), 64'(ins.instr_type));
      check_val("payload",    64'({bus.arith_instr, bus.ram_instr, bus.ld_st_instr}),
                              64'({ins.arith_instr, ins.ram_instr, ins.ld_st_instr}));
      if (!f) done += c;
      cyc++;
      @(negedge clk);
    end
    bus.full = 1'b0;
    check_val("total_copies", 64'(done), 64'(n));
    #1;
    check_val("done_ready", 64'(bus.in_ready), 64'd1);
    check_val("done_no_we", 64'(bus.we), 64'd0);
    #1;
  endtask

  initial begin
    loop_instr_t ins;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.full     = 1'b0;
    scramble_inputs();
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_ready", 64'(bus.in_ready), 64'd0);
    check_val("rst_we",    64'(bus.we), 64'd0);
    check_all_zero("rst");
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("post_rst_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);

    // Two arithmetic copies.
    run_instr(mk(INSTR_TYPE_ARITHMETIC, 14'd20, 9'd0, 10'd0, 18'd0, 18'd0, 18'd0, 18'd0, 16'd2), 0, -1);
    @(negedge clk);
    // Chunking 8,8,4.
    run_instr(mk(INSTR_TYPE_LD_ST, 14'd0, 9'd0, 10'd77, 18'd100, 18'd500, 18'd3, 18'd7, 16'd20), 0, -1);
    @(negedge clk);
    // Backpressure for 3 cycles starting at the second issue cycle.
    run_instr(mk(INSTR_TYPE_ARITHMETIC, 14'h1abc, 9'h155, 10'h2aa, 18'd40, 18'd9, 18'd5, 18'd11, 16'd19), 0, 1);
    @(negedge clk);
    // Zero count followed by a single RAM copy.
    run_instr(mk(INSTR_TYPE_RAM, 14'd3, 9'd3, 10'd3, 18'd3, 18'd3, 18'd3, 18'd3, 16'd0), 0, -1);
    run_instr(mk(INSTR_TYPE_RAM, 14'd0, 9'd45, 10'd0, 18'd12, 18'd34, 18'd1, 18'd1, 16'd1), 0, -1);
    @(negedge clk);
    // Main-memory address wrap.
    run_instr(mk(INSTR_TYPE_RAM, 14'd0, 9'd1, 10'd0, 18'd0, 18'h3FFF0, 18'd0, 18'd4, 16'd16), 0, -1);
    @(negedge clk);

    // Random instructions with random backpressure.
    for (int k = 0; k < 40; k++) begin
      ins = mk(2'($urandom), 14'($urandom), 9'($urandom), 10'($urandom),
               18'($urandom), 18'($urandom), 18'($urandom), 18'($urandom),
               16'($urandom_range(0, 40)));
      run_instr(ins, 30, -1);
      @(negedge clk);
    end

    // Reset in the middle of a 24-copy instruction, right after the first write.
    ins = mk(INSTR_TYPE_LD_ST, 14'h3fff, 9'h1ff, 10'h3ff, 18'd1000, 18'd2000, 18'd2, 18'd3, 16'd24);
    bus.in_valid           = 1'b1;
    bus.in_instr_type      = ins.instr_type;
    bus.in_arith_instr     = ins.arith_instr;
    bus.in_ram_instr       = ins.ram_instr;
    bus.in_ld_st_instr     = ins.ld_st_instr;
    bus.in_cache_addr      = ins.cache_addr;
    bus.in_main_mem_addr   = ins.main_mem_addr;
    bus.in_d_cache_addr    = ins.d_cache_addr;
    bus.in_d_main_mem_addr = ins.d_main_mem_addr;
    bus.in_iter_count      = ins.iter_count;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check_val("mr_first_we", 64'(bus.we), 64'd1);
    check_val("mr_first_cc", 64'(bus.copy_count), 64'd7);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_val("mr_rst_we",    64'(bus.we), 64'd0);
    check_val("mr_rst_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("mr_after_ready", 64'(bus.in_ready), 64'd1);
    check_all_zero("mr_after");
    repeat (4) begin
      #1;
      check_val("mr_no_we", 64'(bus.we), 64'd0);
      @(negedge clk);
    end
    // Normal operation resumes after the abandoned instruction.
    run_instr(mk(INSTR_TYPE_ARITHMETIC, 14'd9, 9'd8, 10'd7, 18'd6, 18'd5, 18'd4, 18'd3, 16'd9), 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instruction_queue_feeder.md
# instruction_queue_feeder

Write-side driver for `instruction_queue`. It accepts one decoded loop instruction per handshake from the control unit, carrying a payload, base addresses, address strides and an iteration count. It splits the iterations into superscalar chunks of at most 2^LOG_SUPERSCALAR_WIDTH copies and issues one queue write per chunk, advancing the base addresses by stride × chunk each time. It sits between the control unit decoder and `instruction_queue`, and honours the queue's `full` backpressure.

## Interface
- LOG_SUPERSCALAR_WIDTH, 3, log2 of max copies per queue write (max chunk = 8)
- ADDR_WIDTH, 18, width of all cache/main-memory addresses and strides
- COUNT_WIDTH, 16, width of iteration count
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  feeder can accept; transfer on `in_valid && in_ready` at rising edge
- in_instr_type  in  2  INSTR_TYPE_* selector
- in_arith_instr  in  [0:13]  arithmetic payload
- in_ram_instr  in  [0:8]  RAM/DMA payload
- in_ld_st_instr  in  [0:9]  load/store payload
- in_cache_addr, in_main_mem_addr  in  ADDR_WIDTH each  base addresses
- in_d_cache_addr, in_d_main_mem_addr  in  ADDR_WIDTH each  per-copy strides
- in_iter_count  in  COUNT_WIDTH  total copies N (true count, not off-by-one)
- full  in  1  instruction_queue cannot take a write this cycle
- we  out  1  queue write enable
- instr_type  out  2  held type
- copy_count  out  LOG_SUPERSCALAR_WIDTH+1  copies in this write minus one
- cache_addr, main_mem_addr  out  ADDR_WIDTH each  chunk base addresses
- d_cache_addr, d_main_mem_addr  out  ADDR_WIDTH each  strides, passed unchanged
- arith_instr [0:13], ram_instr [0:8], ld_st_instr [0:9]  out  held payloads

## Operation
- States: IDLE and ISSUE.
- **IDLE**
  - `in_ready`=1.
  - On transfer with N>0: latch every input field, set remaining=N, go to ISSUE.
  - On transfer with N=0: the instruction is consumed and dropped; stay in IDLE.
- **ISSUE**
  - `in_ready`=0.
  - chunk = min(remaining, 2^LOG_SUPERSCALAR_WIDTH).
  - `we` = !full (combinational from state and `full`).
  - `copy_count` = chunk−1. All other outputs come from the held registers.
- **On a write cycle** (`we`=1):
  - remaining -= chunk.
  - cache_addr += d_cache_addr × chunk and main_mem_addr += d_main_mem_addr × chunk, both modulo 2^ADDR_WIDTH (wrap, no saturation).
  - If remaining==chunk, go to IDLE.
- **When `full`=1**: no write, no register update, all outputs stable.
- `instr_type` and all three payload fields pass through as latched. The feeder never inspects the payload.
- Stride multiply is by chunk ≤ 2^LOG_SUPERSCALAR_WIDTH. Implement it as shift-add and truncate to ADDR_WIDTH.
- **Reset** (sync, any state, including mid-ISSUE):
  - Next state IDLE; remaining and all held registers cleared to 0.
  - Remaining chunks are abandoned.
  - While `reset` is sampled high: `we`=0 and `in_ready`=0.
- **Reset values of outputs**: we=0, in_ready=0 during reset then 1; instr_type=0, copy_count=0, all addresses and payloads 0.

## Timing
- Input accepted at edge T. First `we` is visible in the cycle after T if `full`=0.
- Throughput is one queue write per cycle while `full`=0.
- Last write at edge W; `in_ready`=1 in the cycle after W.
- This gives exactly one idle handshake cycle between instructions. Back-to-back acceptance is not supported.
- `full` is sampled in the same cycle as `we`. The queue registers the write at the edge where `we`=1.
- `in_*` inputs are ignored outside the transfer edge.

## Structure
- The INSTR_TYPE_* constants and the payload widths (14/9/10) stay in the shared control-unit types package.
- Add to that package:
  - the feeder state enum (FEEDER_IDLE, FEEDER_ISSUE);
  - a packed struct bundling one loop instruction (type, payloads, addresses, strides, count).
- One sub-module, `addr_advance`: combinational base + stride × chunk with modulo wrap. It is instantiated twice (cache and main memory).

## Test plan
- **Two arithmetic copies:** N=2, arithmetic type, in_arith_instr=20, full=0 -> one write the cycle after accept with copy_count=1, instr_type=ARITHMETIC, arith_instr=20; in_ready=1 the following cycle.
- **Chunking:** N=20, cache_addr=100, d_cache_addr=3 -> three consecutive writes, copy_count 7,7,3, cache_addr 100,124,148; d_cache_addr=3 on all three.
- **Backpressure:** full=1 for 3 cycles mid-ISSUE -> we=0 and outputs unchanged for those cycles; the next write resumes with the same copy_count/addresses; total copies still N.
- **Zero count:** N=0 -> accepted, no write ever, in_ready stays 1; a following N=1 RAM instruction (ram_instr=45) gives one write with copy_count=0.
- **Address wrap:** main_mem_addr=0x3FFF0, d_main_mem_addr=4, N=16 -> writes at 0x3FFF0 then 0x00010.
- **Reset mid-operation:** N=24, reset asserted for one cycle after the first write -> we=0 from the reset cycle on, no further writes, all outputs 0, in_ready=1 the cycle after reset deasserts.
